sky130_fd_io__amuxbus_arbiter: RTL and testbench
================================================

// Module: sky130_fd_io__amuxbus_arbiter
// PURPOSE
//   Shares the two analog mux buses (AMUXBUS_A, AMUXBUS_B) among NREQ pad-side requesters.
//   Grants each bus round-robin with break-before-make switch sequencing and a settle delay
//   before grant. Drives the per-pad bus-switch enables. Sits in the digital control domain
//   beside the pad ring.
// PARAMETERS
//   NREQ           4  number of requesters (2..16)
//   BBM_CYCLES     2  cycles all switches of a bus stay off before a new switch closes (>=1)
//   SETTLE_CYCLES  3  cycles after switch close before GNT asserts (>=1)
// PORTS
//   CLK       in   1     clock
//   RESET_B   in   1     asynchronous active-low reset
//   DISABLE   in   1     sync force-off: opens all switches, both buses to IDLE
//   REQ       in   NREQ  request, held high for duration of use
//   BUS_SEL   in   NREQ  per requester: 0 = bus A, 1 = bus B; valid while REQ high
//   GNT       out  NREQ  bus connected and settled for requester i
//   ENA_A     out  NREQ  switch enable, pad i to AMUXBUS_A (registered)
//   ENA_B     out  NREQ  switch enable, pad i to AMUXBUS_B (registered)
//   BUSY_A    out  1     bus A FSM not IDLE
//   BUSY_B    out  1     bus B FSM not IDLE
// BEHAVIOUR
//   - One independent FSM per bus X in {A,B}: IDLE, BREAK, MAKE, OWN. Candidates for X: REQ[i] & (BUS_SEL[i]==X).
//   - Reset (RESET_B low): all outputs 0, FSMs IDLE, counters 0, RR pointers = NREQ-1 (index 0 wins first).
//   - IDLE: any candidate sampled at edge k -> pick winner w = first candidate after pointer (wrapping);
//     pointer <= w; BREAK, cnt <= BBM_CYCLES-1.
//   - BREAK: all ENA_X low; cnt decrements each cycle; at cnt==0 -> MAKE, ENA_X[w] <= 1, cnt <= SETTLE_CYCLES-1.
//   - MAKE: ENA_X[w] high; at cnt==0 -> OWN, GNT[w] <= 1.
//   - Latency: REQ sampled at edge k -> ENA_X[w] high after edge k+BBM_CYCLES, GNT[w] after edge
//     k+BBM_CYCLES+SETTLE_CYCLES (defaults: k+2, k+5).
//   - OWN: holds while REQ[w] & BUS_SEL[w]==X. Release (REQ[w] low or BUS_SEL[w] flips) sampled at edge m ->
//     GNT[w], ENA_X[w] low after edge m; -> BREAK for BBM_CYCLES; then IDLE (re-arbitrate next cycle).
//   - Abort in BREAK/MAKE (winner drops REQ or flips BUS_SEL): ENA_X[w] low next edge, restart BREAK
//     count, then IDLE. GNT never asserts for an aborted request.
//   - Ownership non-preemptive; other requests wait. Pointer advances only on winner selection.
//   - Invariants: at most one ENA_A bit and one ENA_B bit high; never ENA_A[i] & ENA_B[i]; GNT[i] implies ENA of
//     its bus; between two different owners of a bus, >= BBM_CYCLES cycles with all that bus's ENA low.
//   - Requester flipping BUS_SEL while owning A: releases A (through BREAK), then competes for B as a fresh request.
//   - DISABLE high sampled: all GNT/ENA low next edge, FSMs IDLE, pointers kept; requests ignored while high.
//     On DISABLE low, arbitration resumes from IDLE with full BREAK.
//   - Simultaneous candidates on A and B: FSMs independent; both buses may be granted the same cycle.
//   - RESET_B asserted mid-operation: outputs clear immediately (async); no sequencing on reset.
// TESTING
//   1. Reset, REQ=0001, BUS_SEL=0 at edge 1 -> ENA_A=0001 after edge 3, GNT=0001 after edge 6, ENA_B=0.
//   2. REQ=1111, BUS_SEL=0000 held; each owner drops REQ 4 cycles after GNT -> grant order 0,1,2,3,0; each ENA_A
//      handoff has >=2 all-low cycles.
//   3. REQ=0011, BUS_SEL=0010 -> req0 gets A, req1 gets B, both GNT after same edge.
//   4. Req0 owns A, flips BUS_SEL to 1 -> GNT[0], ENA_A[0] low next edge; ENA_B[0] high BBM_CYCLES later, GNT after settle.
//   5. Req2 drops REQ during MAKE -> ENA_A[2] low next edge, GNT[2] never high, bus A back to IDLE after 2 cycles.
//   6. DISABLE pulse while both buses owned -> all outputs 0 next edge; RESET_B low mid-MAKE -> outputs 0 asynchronously.

Source files
------------

// File: rtl/sky130_fd_io__amuxbus_arbiter.sv
// Shares AMUXBUS_A/AMUXBUS_B among NREQ pads: round-robin winner per bus, break-before-make
// switch sequencing and a settle delay before grant. One independent FSM per bus.
module sky130_fd_io__amuxbus_arbiter #(
  parameter int NREQ          = 4,
  parameter int BBM_CYCLES    = 2,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic            CLK,
  input  logic            RESET_B,
  input  logic            DISABLE,
  input  logic [NREQ-1:0] REQ,
  input  logic [NREQ-1:0] BUS_SEL,
  output logic [NREQ-1:0] GNT,
  output logic [NREQ-1:0] ENA_A,
  output logic [NREQ-1:0] ENA_B,
  output logic            BUSY_A,
  output logic            BUSY_B
);

  localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CMAX = (BBM_CYCLES > SETTLE_CYCLES) ? BBM_CYCLES : SETTLE_CYCLES;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  localparam logic [PW-1:0] PTR_RST = PW'(NREQ - 1);
  localparam logic [CW-1:0] BBM_LD  = CW'(BBM_CYCLES - 1);
  localparam logic [CW-1:0] SET_LD  = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BREAK = 2'd1,
    S_MAKE  = 2'd2,
    S_OWN   = 2'd3
  } state_e;

  function automatic logic [PW-1:0] rr_step(input logic [PW-1:0] base, input int ofs);
    int s;
    s = int'(base) + ofs;
    if (s >= NREQ) begin
      s = s - NREQ;
    end else begin
      s = s;
    end
    return s[PW-1:0];
  endfunction

  for (genvar b = 0; b < 2; b++) begin : g_bus
    state_e          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   ptr_q;
    logic [PW-1:0]   win_q;
    logic            rel_q;
    logic [NREQ-1:0] ena_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] cand_s;
    logic [NREQ-1:0] win_oh_s;
    logic [PW-1:0]   pick_s;
    logic            found_s;
    logic            win_ok_s;

    assign cand_s   = (b == 0) ? (REQ & ~BUS_SEL) : (REQ & BUS_SEL);
    assign win_ok_s = cand_s[win_q];
    assign win_oh_s = {{(NREQ-1){1'b0}}, 1'b1} << win_q;

    // Round-robin pick: first candidate after the pointer, the pointer itself tried last.
    always_comb begin
      pick_s  = ptr_q;
      found_s = 1'b0;
      for (int j = 1; j <= NREQ; j++) begin
        if (!found_s && cand_s[rr_step(ptr_q, j)]) begin
          found_s = 1'b1;
          pick_s  = rr_step(ptr_q, j);
        end else begin
          pick_s  = pick_s;
        end
      end
    end

    // Bus FSM; rel_q marks a BREAK that ends in IDLE (release/abort) rather than MAKE.
    always_ff @(posedge CLK or negedge RESET_B) begin
      if (!RESET_B) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        ptr_q   <= PTR_RST;
        win_q   <= '0;
        rel_q   <= 1'b0;
        ena_q   <= '0;
        gnt_q   <= '0;
      end else if (DISABLE) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        rel_q   <= 1'b0;
        ena_q   <= '0;
        gnt_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (found_s) begin
              ptr_q   <= pick_s;
              win_q   <= pick_s;
              state_q <= S_BREAK;
              cnt_q   <= BBM_LD;
              rel_q   <= 1'b0;
            end
          end
          S_BREAK: begin
            if (!rel_q && !win_ok_s) begin
              cnt_q <= BBM_LD;
              rel_q <= 1'b1;
            end else if (cnt_q == '0) begin
              if (rel_q) begin
                state_q <= S_IDLE;
                rel_q   <= 1'b0;
              end else begin
                state_q <= S_MAKE;
                ena_q   <= win_oh_s;
                cnt_q   <= SET_LD;
              end
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          S_MAKE: begin
            if (!win_ok_s) begin
              ena_q   <= '0;
              state_q <= S_BREAK;
              cnt_q   <= BBM_LD;
              rel_q   <= 1'b1;
            end else if (cnt_q == '0) begin
              state_q <= S_OWN;
              gnt_q   <= win_oh_s;
            end else begin
              cnt_q <= cnt_q - CNT_ONE;
            end
          end
          S_OWN: begin
            if (!win_ok_s) begin
              ena_q   <= '0;
              gnt_q   <= '0;
              state_q <= S_BREAK;
              cnt_q   <= BBM_LD;
              rel_q   <= 1'b1;
            end
          end
          default: begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rel_q   <= 1'b0;
            ena_q   <= '0;
            gnt_q   <= '0;
          end
        endcase
      end
    end
  end

  assign ENA_A  = g_bus[0].ena_q;
  assign ENA_B  = g_bus[1].ena_q;
  assign GNT    = g_bus[0].gnt_q | g_bus[1].gnt_q;
  assign BUSY_A = (g_bus[0].state_q != S_IDLE);
  assign BUSY_B = (g_bus[1].state_q != S_IDLE);

endmodule

// File: tb/tb_sky130_fd_io__amuxbus_arbiter.sv
// Bench for the AMUXBUS arbiter: directed scenarios plus random traffic against a
// timestamp-based reference model of each bus.
module tb_sky130_fd_io__amuxbus_arbiter;
  localparam int NREQ   = 4;
  localparam int BBM    = 2;
  localparam int SETTLE = 3;

  logic            CLK = 1'b0;
  logic            RESET_B = 1'b0;
  logic            DISABLE = 1'b0;
  logic [NREQ-1:0] REQ = '0;
  logic [NREQ-1:0] BUS_SEL = '0;
  logic [NREQ-1:0] GNT, ENA_A, ENA_B;
  logic            BUSY_A, BUSY_B;

  always #5 CLK = ~CLK;

  sky130_fd_io__amuxbus_arbiter #(.NREQ(NREQ), .BBM_CYCLES(BBM), .SETTLE_CYCLES(SETTLE)) dut (
    .CLK(CLK), .RESET_B(RESET_B), .DISABLE(DISABLE), .REQ(REQ), .BUS_SEL(BUS_SEL),
    .GNT(GNT), .ENA_A(ENA_A), .ENA_B(ENA_B), .BUSY_A(BUSY_A), .BUSY_B(BUSY_B)
  );

  int vectors = 0;
  int errors  = 0;

  // Model: per bus the current winner, the edge it was chosen, the first edge the bus may
  // arbitrate again, and the round-robin pointer. Outputs follow from elapsed edges.
  int              n = 0;
  int              m_owner[2];
  int              m_tsel[2];
  int              m_tfree[2];
  int              m_ptr[2];
  logic [NREQ-1:0] exp_ena[2];
  logic [NREQ-1:0] exp_gnt;
  logic            exp_busy[2];
  logic [3*NREQ+1:0] exp_vec;
  logic [3*NREQ+1:0] dut_vec;
  assign dut_vec = {GNT, ENA_A, ENA_B, BUSY_A, BUSY_B};

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      m_owner[b] = -1;
      m_tsel[b]  = 0;
      m_tfree[b] = n;
      m_ptr[b]   = NREQ - 1;
    end
    exp_vec = '0;
  endtask

  task automatic model_step();
    logic [NREQ-1:0] c;
    n++;
    exp_gnt = '0;
    for (int b = 0; b < 2; b++) begin
      c = (b == 0) ? (REQ & ~BUS_SEL) : (REQ & BUS_SEL);
      if (DISABLE) begin
        m_owner[b] = -1;
        m_tfree[b] = n + 1;
      end else if (m_owner[b] >= 0) begin
        if (!c[m_owner[b]]) begin
          m_owner[b] = -1;
          m_tfree[b] = n + BBM + 1;
        end
      end else if (n >= m_tfree[b] && c != '0) begin
        for (int j = 1; j <= NREQ; j++)
          if (m_owner[b] < 0 && c[(m_ptr[b] + j) % NREQ]) m_owner[b] = (m_ptr[b] + j) % NREQ;
        m_ptr[b]  = m_owner[b];
        m_tsel[b] = n;
      end
      exp_ena[b] = '0;
      if (m_owner[b] >= 0 && n >= m_tsel[b] + BBM) exp_ena[b][m_owner[b]] = 1'b1;
      if (m_owner[b] >= 0 && n >= m_tsel[b] + BBM + SETTLE) exp_gnt[m_owner[b]] = 1'b1;
      exp_busy[b] = (m_owner[b] >= 0) || (n < m_tfree[b] - 1);
    end
    exp_vec = {exp_gnt, exp_ena[0], exp_ena[1], exp_busy[0], exp_busy[1]};
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  task automatic apply_reset();
    RESET_B = 1'b0;
    REQ = '0;
    BUS_SEL = '0;
    DISABLE = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RESET_B = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    vectors++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", dut_vec);
    end
    for (int e = 1; e <= 3; e++) begin
      tick();
      vectors++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL reset_idle edge %0d: got %h expected %h", e, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_single();
    logic [NREQ-1:0] ea, eg;
    apply_reset();
    REQ = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      ea = (e >= 3) ? 4'b0001 : 4'b0000;
      eg = (e >= 6) ? 4'b0001 : 4'b0000;
      vectors++;
      if (ENA_A !== ea || GNT !== eg || ENA_B !== 4'b0000) begin
        errors++;
        $display("FAIL single edge %0d: got ENA_A=%b GNT=%b ENA_B=%b expected %b %b 0000", e, ENA_A, GNT, ENA_B, ea, eg);
      end
      vectors++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL single_model edge %0d: got %h expected %h", e, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int lowcnt;
    bit seen;
    apply_reset();
    REQ = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        tick();
        vectors++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL rr_model: got %h expected %h", dut_vec, exp_vec);
        end
        seen = (GNT != '0);
      end
      vectors++;
      if (GNT !== (4'b0001 << order[g])) begin
        errors++;
        $display("FAIL rr_order grant %0d: got GNT=%b expected owner %0d", g, GNT, order[g]);
      end
      for (int h = 0; h < 4; h++) begin
        tick();
        vectors++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL rr_hold: got %h expected %h", dut_vec, exp_vec);
        end
      end
      REQ[order[g]] = 1'b0;
      tick();
      lowcnt = (ENA_A == '0) ? 1 : 0;
      REQ[order[g]] = 1'b1;
      if (g < 4) begin
        seen = 1'b0;
        for (int t = 0; t < 40 && !seen; t++) begin
          tick();
          vectors++;
          if (dut_vec !== exp_vec) begin
            errors++;
            $display("FAIL rr_handoff_model: got %h expected %h", dut_vec, exp_vec);
          end
          seen = (ENA_A != '0);
          if (!seen) lowcnt++;
        end
        vectors++;
        if (!seen || lowcnt < BBM) begin
          errors++;
          $display("FAIL rr_bbm handoff %0d: got %0d all-low cycles (new switch seen=%0d) expected >= %0d", g, lowcnt, seen, BBM);
        end
      end
    end
  endtask

  task automatic test_dual();
    logic [NREQ-1:0] eg;
    apply_reset();
    REQ = 4'b0011;
    BUS_SEL = 4'b0010;
    for (int e = 1; e <= 7; e++) begin
      tick();
      eg = (e >= 6) ? 4'b0011 : 4'b0000;
      vectors++;
      if (GNT !== eg) begin
        errors++;
        $display("FAIL dual edge %0d: got GNT=%b expected %b", e, GNT, eg);
      end
      vectors++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL dual_model edge %0d: got %h expected %h", e, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_flip();
    logic [NREQ-1:0] eb, eg;
    bit seen;
    apply_reset();
    REQ = 4'b0001;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = (GNT == 4'b0001);
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL flip_setup: got GNT=%b expected 0001 within 20 cycles", GNT);
    end
    BUS_SEL = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      tick();
      eb = (e >= 3) ? 4'b0001 : 4'b0000;
      eg = (e >= 6) ? 4'b0001 : 4'b0000;
      vectors++;
      if (ENA_A !== 4'b0000 || ENA_B !== eb || GNT !== eg) begin
        errors++;
        $display("FAIL flip edge %0d: got ENA_A=%b ENA_B=%b GNT=%b expected 0000 %b %b", e, ENA_A, ENA_B, GNT, eb, eg);
      end
      vectors++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL flip_model edge %0d: got %h expected %h", e, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_abort();
    logic [NREQ-1:0] ea;
    logic eb;
    apply_reset();
    REQ = 4'b0100;
    for (int e = 1; e <= 8; e++) begin
      tick();
      ea = (e == 3) ? 4'b0100 : 4'b0000;
      eb = (e <= 5);
      vectors++;
      if (ENA_A !== ea || BUSY_A !== eb || GNT[2] !== 1'b0) begin
        errors++;
        $display("FAIL abort edge %0d: got ENA_A=%b BUSY_A=%b GNT=%b expected %b %b 0000", e, ENA_A, BUSY_A, GNT, ea, eb);
      end
      vectors++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL abort_model edge %0d: got %h expected %h", e, dut_vec, exp_vec);
      end
      if (e == 3) REQ = 4'b0000;
    end
  endtask

  task automatic test_disable_reset();
    bit seen;
    apply_reset();
    REQ = 4'b0011;
    BUS_SEL = 4'b0010;
    seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      tick();
      seen = (GNT == 4'b0011);
    end
    vectors++;
    if (!seen) begin
      errors++;
      $display("FAIL disable_setup: got GNT=%b expected 0011 within 20 cycles", GNT);
    end
    DISABLE = 1'b1;
    tick();
    vectors++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL disable_off: got %h expected 0", dut_vec);
    end
    DISABLE = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      tick();
      vectors++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL disable_resume edge %0d: got %h expected %h", e, dut_vec, exp_vec);
      end
    end
    vectors++;
    if (GNT !== 4'b0011) begin
      errors++;
      $display("FAIL disable_regrant: got GNT=%b expected 0011", GNT);
    end
    REQ = 4'b0000;
    for (int e = 0; e < 6; e++) tick();
    REQ = 4'b0001;
    BUS_SEL = 4'b0000;
    for (int e = 1; e <= 3; e++) tick();
    vectors++;
    if (ENA_A !== 4'b0001 || GNT !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_make_setup: got ENA_A=%b GNT=%b expected 0001 0000", ENA_A, GNT);
    end
    #2 RESET_B = 1'b0;
    #1;
    vectors++;
    if (dut_vec !== '0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", dut_vec);
    end
    @(negedge CLK);
    RESET_B = 1'b1;
    model_reset();
    tick();
    vectors++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL after_reset: got %h expected %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int t = 0; t < 1500; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0) REQ[i] = ~REQ[i];
        if ($urandom_range(0, 15) == 0) BUS_SEL[i] = ~BUS_SEL[i];
      end
      DISABLE = ($urandom_range(0, 63) == 0);
      tick();
      vectors++;
      if (dut_vec !== exp_vec) begin
        errors++;
        $display("FAIL random_model cycle %0d: got %h expected %h", t, dut_vec, exp_vec);
      end
      vectors++;
      if ($countones(ENA_A) > 1 || $countones(ENA_B) > 1 || (ENA_A & ENA_B) != '0 ||
          (GNT & ~(ENA_A | ENA_B)) != '0) begin
        errors++;
        $display("FAIL random_invariant cycle %0d: got ENA_A=%b ENA_B=%b GNT=%b", t, ENA_A, ENA_B, GNT);
      end
    end
    DISABLE = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_dual();
    test_flip();
    test_abort();
    test_disable_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
